// File: rtl/regfile_pkg.sv
// Shared definitions for the parameterised register file: controller state
// encoding and the address-width helper.
package regfile_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } rf_state_e;

  // Ceiling log2, evaluated at elaboration time for address widths.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/regfile_bypass_mux.sv
// Read-port selection: forces zero for out-of-range or hard-wired-zero
// addresses, otherwise forwards a same-cycle write or returns the stored word.
module regfile_bypass_mux #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = 4,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [WIDTH-1:0]  mem_data,
  input  logic              wr_fire,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  output logic [WIDTH-1:0]  data
);

  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);

  logic in_range;
  logic is_zero_reg;

  assign in_range    = ({1'b0, rd_addr} < DEPTH_V);
  assign is_zero_reg = (ZERO_REG != 0) && (rd_addr == '0);

  always_comb begin
    data = mem_data;
    if (!in_range || is_zero_reg) begin
      data = '0;
    end else if ((BYPASS != 0) && wr_fire && (wr_addr == rd_addr)) begin
      data = wr_data;
    end
  end

endmodule

// File: rtl/regfile_param.sv
// Parameterised 1-write / 2-read register file with registered reads and a
// sequential zeroing sweep used both after reset and on clr_req.
module regfile_param
  import regfile_pkg::*;
#(
  parameter int  WIDTH    = 16,
  parameter int  DEPTH    = 16,
  parameter int  ZERO_REG = 0,
  parameter int  BYPASS   = 1,
  localparam int ADDR_W   = (clog2(DEPTH) > 1) ? clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              clr_req,
  output logic              busy,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [WIDTH-1:0]  rd_data_a,
  output logic [WIDTH-1:0]  rd_data_b,
  output logic              rd_valid
);

  localparam logic [ADDR_W:0]   DEPTH_V  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  rf_state_e         state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;

  logic [WIDTH-1:0]  mem [DEPTH];

  logic              active;
  logic              idle;
  logic              wr_ok;
  logic              wr_fire;
  logic              clr_fire;
  logic              rd_fire;
  logic [WIDTH-1:0]  sel_a, sel_b;

  // Memory has no reset of its own; the sweep after reset zeroes it.
  assign active   = en && !reset;
  assign idle     = (state_q == ST_IDLE);
  assign wr_ok    = ({1'b0, wr_addr} < DEPTH_V) && !((ZERO_REG != 0) && (wr_addr == '0));
  assign wr_fire  = active && idle && wr_en && !clr_req && wr_ok;
  assign clr_fire = active && !idle;
  assign rd_fire  = active && idle && rd_en;
  assign busy     = !idle;

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    if (en) begin
      case (state_q)
        ST_CLEAR: begin
          if (clr_ptr_q == LAST_PTR) begin
            state_d = ST_IDLE;
          end else begin
            clr_ptr_d = clr_ptr_q + 1'b1;
          end
        end
        ST_IDLE: begin
          if (clr_req) begin
            state_d   = ST_CLEAR;
            clr_ptr_d = '0;
          end
        end
        default: state_d = ST_CLEAR;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_CLEAR;
      clr_ptr_q <= '0;
      rd_data_a <= '0;
      rd_data_b <= '0;
      rd_valid  <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      rd_valid  <= rd_fire;
      if (rd_fire) begin
        rd_data_a <= sel_a;
        rd_data_b <= sel_b;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr_fire) begin
      mem[clr_ptr_q] <= '0;
    end else if (wr_fire) begin
      mem[wr_addr] <= wr_data;
    end
  end

  regfile_bypass_mux #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS)
  ) u_mux_a (
    .rd_addr  (rd_addr_a),
    .mem_data (mem[rd_addr_a]),
    .wr_fire  (wr_fire),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .data     (sel_a)
  );

  regfile_bypass_mux #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS)
  ) u_mux_b (
    .rd_addr  (rd_addr_b),
    .mem_data (mem[rd_addr_b]),
    .wr_fire  (wr_fire),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .data     (sel_b)
  );

endmodule
